// File: rtl/axi_tdd_ng_counter.sv
`default_nettype none
// ============================================================================
// Module   : axi_tdd_ng_counter
// Brief    : TDD timing engine (arm, sync, startup delay, framed burst count).
// Revision : 1.0 - initial release
// ============================================================================

package axi_tdd_ng_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        WAITING = 2'd2,
        RUNNING = 2'd3
    } state_t;
endpackage

module axi_tdd_ng_counter
    import axi_tdd_ng_pkg::*;
#(
    parameter int REGISTER_WIDTH    = 32,
    parameter int BURST_COUNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         tdd_enable,
    input  logic                         tdd_sync_en,
    input  logic                         tdd_sync_int,
    input  logic                         tdd_sync_ext,
    input  logic                         tdd_sync_soft,
    input  logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
    input  logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
    input  logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
    output logic [REGISTER_WIDTH-1:0]    tdd_counter,
    output state_t                       tdd_cstate,
    output logic                         tdd_endof_frame,
    output logic                         tdd_endof_burst
);

    localparam logic [REGISTER_WIDTH-1:0]    c_REG_ONE   = 1;
    localparam logic [BURST_COUNT_WIDTH-1:0] c_BURST_ONE = 1;

    state_t                       r_state;
    logic [REGISTER_WIDTH-1:0]    r_counter;
    logic [BURST_COUNT_WIDTH-1:0] r_frame;
    logic                         r_eof;
    logic                         r_eob;
    logic [REGISTER_WIDTH-1:0]    r_delay;
    logic [REGISTER_WIDTH-1:0]    r_length;
    logic [BURST_COUNT_WIDTH-1:0] r_burst;

    state_t                       w_state_nxt;
    logic [REGISTER_WIDTH-1:0]    w_counter_nxt;
    logic [BURST_COUNT_WIDTH-1:0] w_frame_nxt;
    logic                         w_eof_nxt;
    logic                         w_eob_nxt;
    logic                         w_capture;
    logic                         w_sync;
    logic [REGISTER_WIDTH-1:0]    w_t;
    logic                         w_t_zero;
    logic                         w_last_frame;

    assign w_sync       = tdd_sync_soft | (tdd_sync_en & (tdd_sync_int | tdd_sync_ext));
    // A zero frame length behaves as a one-cycle frame
    assign w_t          = (r_length == '0) ? '0 : r_length - c_REG_ONE;
    assign w_t_zero     = (w_t == '0);
    assign w_last_frame = (r_burst != '0) && (r_frame + c_BURST_ONE == r_burst);

    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_frame_nxt   = r_frame;
        w_eof_nxt     = 1'b0;
        w_eob_nxt     = 1'b0;
        w_capture     = 1'b0;
        if (!tdd_enable) begin
            w_state_nxt   = IDLE;
            w_counter_nxt = '0;
            w_frame_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt   = ARMED;
                    w_counter_nxt = '0;
                end
                ARMED: begin
                    w_counter_nxt = '0;
                    w_frame_nxt   = '0;
                    if (w_sync) begin
                        w_capture = 1'b1;
                        if (tdd_startup_delay != '0) begin
                            w_state_nxt = WAITING;
                        end else begin
                            // Shadows load this edge, so flags look at the raw inputs
                            w_state_nxt = RUNNING;
                            w_eof_nxt   = (tdd_frame_length <= c_REG_ONE);
                            w_eob_nxt   = w_eof_nxt && (tdd_burst_count == c_BURST_ONE);
                        end
                    end
                end
                WAITING: begin
                    if (r_counter == r_delay - c_REG_ONE) begin
                        w_state_nxt   = RUNNING;
                        w_counter_nxt = '0;
                        w_eof_nxt     = w_t_zero;
                        w_eob_nxt     = w_t_zero && (r_burst == c_BURST_ONE);
                    end else begin
                        w_counter_nxt = r_counter + c_REG_ONE;
                    end
                end
                RUNNING: begin
                    if (r_counter == w_t) begin
                        w_counter_nxt = '0;
                        if (w_last_frame) begin
                            w_state_nxt = ARMED;
                            w_frame_nxt = '0;
                        end else begin
                            if (r_burst != '0) begin
                                w_frame_nxt = r_frame + c_BURST_ONE;
                            end
                            w_eof_nxt = w_t_zero;
                            w_eob_nxt = w_t_zero && (r_burst != '0)
                                        && (w_frame_nxt + c_BURST_ONE == r_burst);
                        end
                    end else begin
                        w_counter_nxt = r_counter + c_REG_ONE;
                        w_eof_nxt     = (w_counter_nxt == w_t);
                        w_eob_nxt     = w_eof_nxt && w_last_frame;
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_counter_nxt = '0;
                    w_frame_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_frame   <= '0;
            r_eof     <= 1'b0;
            r_eob     <= 1'b0;
            r_delay   <= '0;
            r_length  <= '0;
            r_burst   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            r_frame   <= w_frame_nxt;
            r_eof     <= w_eof_nxt;
            r_eob     <= w_eob_nxt;
            if (w_capture) begin
                r_delay  <= tdd_startup_delay;
                r_length <= tdd_frame_length;
                r_burst  <= tdd_burst_count;
            end
        end
    end

    assign tdd_counter     = r_counter;
    assign tdd_cstate      = r_state;
    assign tdd_endof_frame = r_eof;
    assign tdd_endof_burst = r_eob;

endmodule
`default_nettype wire

// File: tb/tb_axi_tdd_ng_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_tdd_ng_counter
// Brief    : Directed self-checking bench for axi_tdd_ng_counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_tdd_ng_counter;
    import axi_tdd_ng_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        tdd_enable = 1'b0;
    logic        tdd_sync_en = 1'b0;
    logic        tdd_sync_int = 1'b0;
    logic        tdd_sync_ext = 1'b0;
    logic        tdd_sync_soft = 1'b0;
    logic [31:0] tdd_startup_delay = '0;
    logic [31:0] tdd_frame_length = '0;
    logic [31:0] tdd_burst_count = '0;
    logic [31:0] tdd_counter;
    state_t      tdd_cstate;
    logic        tdd_endof_frame;
    logic        tdd_endof_burst;

    int n_tests = 0;
    int n_fail  = 0;

    axi_tdd_ng_counter #(.REGISTER_WIDTH(32), .BURST_COUNT_WIDTH(32)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .tdd_enable        (tdd_enable),
        .tdd_sync_en       (tdd_sync_en),
        .tdd_sync_int      (tdd_sync_int),
        .tdd_sync_ext      (tdd_sync_ext),
        .tdd_sync_soft     (tdd_sync_soft),
        .tdd_startup_delay (tdd_startup_delay),
        .tdd_frame_length  (tdd_frame_length),
        .tdd_burst_count   (tdd_burst_count),
        .tdd_counter       (tdd_counter),
        .tdd_cstate        (tdd_cstate),
        .tdd_endof_frame   (tdd_endof_frame),
        .tdd_endof_burst   (tdd_endof_burst)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are then stable for sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input state_t st, input logic [31:0] cnt,
                             input logic eof, input logic eob);
        check({tag, ".state"}, 32'(tdd_cstate), 32'(st));
        check({tag, ".cnt"},   tdd_counter, cnt);
        check({tag, ".eof"},   32'(tdd_endof_frame), 32'(eof));
        check({tag, ".eob"},   32'(tdd_endof_burst), 32'(eob));
    endtask

    // Delay 2, length 3, burst 1 from ARMED: W0 W1 R0 R1 R2(eof,eob) ARMED
    task automatic fresh_burst(input string tag);
        tdd_startup_delay = 32'd2;
        tdd_frame_length  = 32'd3;
        tdd_burst_count   = 32'd1;
        tdd_sync_soft = 1'b1;
        tick();
        tdd_sync_soft = 1'b0;
        check_all({tag, ".w0"}, WAITING, 0, 1'b0, 1'b0); tick();
        check_all({tag, ".w1"}, WAITING, 1, 1'b0, 1'b0); tick();
        check_all({tag, ".r0"}, RUNNING, 0, 1'b0, 1'b0); tick();
        check_all({tag, ".r1"}, RUNNING, 1, 1'b0, 1'b0); tick();
        check_all({tag, ".r2"}, RUNNING, 2, 1'b1, 1'b1); tick();
        check_all({tag, ".arm"}, ARMED, 0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_all("reset", IDLE, 0, 1'b0, 1'b0);
        resetn = 1'b1;
        repeat (5) tick();
        check_all("idle", IDLE, 0, 1'b0, 1'b0);

        // Enable, no sync: ARMED and stays there
        tdd_enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_all("armed_hold", ARMED, 0, 1'b0, 1'b0);
            tick();
        end

        // Delay 3, length 5, burst 2; length changed mid-burst; sync at end-of-burst lost
        tdd_startup_delay = 32'd3;
        tdd_frame_length  = 32'd5;
        tdd_burst_count   = 32'd2;
        tdd_sync_soft = 1'b1;
        tick();
        tdd_sync_soft = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k <= 3)
                check_all($sformatf("burst1.k%0d", k), WAITING, 32'(k - 1), 1'b0, 1'b0);
            else if (k <= 13)
                check_all($sformatf("burst1.k%0d", k), RUNNING, 32'((k - 4) % 5),
                          ((k - 4) % 5) == 4, k == 13);
            else
                check_all("burst1.k14", ARMED, 0, 1'b0, 1'b0);
            if (k == 6) tdd_frame_length = 32'd8;
            tdd_sync_soft = (k == 13) || (k == 14);
            if (k == 14) begin
                tdd_startup_delay = 32'd0;
                tdd_burst_count   = 32'd1;
            end
            if (k < 14) tick();
        end

        // Restart from the first ARMED cycle: delay 0, length 8, burst 1
        tick();
        tdd_sync_soft = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check_all($sformatf("burst2.c%0d", c), RUNNING, 32'(c), c == 7, c == 7);
            tick();
        end
        check_all("burst2.arm", ARMED, 0, 1'b0, 1'b0);

        // Delay 0, length 0, burst 0 on gated external sync: eof every cycle
        tdd_frame_length = 32'd0;
        tdd_burst_count  = 32'd0;
        tdd_sync_en  = 1'b1;
        tdd_sync_ext = 1'b1;
        tick();
        tdd_sync_ext = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_all("len0", RUNNING, 0, 1'b1, 1'b0);
            tick();
        end

        // Disable while eof is high: IDLE with flags cleared
        tdd_enable = 1'b0;
        tick();
        check_all("disable_eof", IDLE, 0, 1'b0, 1'b0);
        tdd_enable = 1'b1;
        tick();
        check_all("reenable", ARMED, 0, 1'b0, 1'b0);

        // Gated syncs are ignored, soft sync starts
        tdd_sync_en  = 1'b0;
        tdd_sync_ext = 1'b1;
        tdd_sync_int = 1'b1;
        tdd_frame_length = 32'd5;
        tick();
        tdd_sync_ext = 1'b0;
        tdd_sync_int = 1'b0;
        check_all("gated_sync", ARMED, 0, 1'b0, 1'b0);
        tdd_sync_soft = 1'b1;
        tick();
        tdd_sync_soft = 1'b0;
        check_all("soft_r0", RUNNING, 0, 1'b0, 1'b0); tick();
        check_all("soft_r1", RUNNING, 1, 1'b0, 1'b0); tick();
        check_all("soft_r2", RUNNING, 2, 1'b0, 1'b0);

        // Drop enable at counter 2, then a fresh burst
        tdd_enable = 1'b0;
        tick();
        check_all("drop_en", IDLE, 0, 1'b0, 1'b0);
        tdd_enable = 1'b1;
        tick();
        fresh_burst("fresh_en");

        // Same with a reset pulse mid-frame
        tdd_startup_delay = 32'd0;
        tdd_frame_length  = 32'd5;
        tdd_burst_count   = 32'd0;
        tdd_sync_soft = 1'b1;
        tick();
        tdd_sync_soft = 1'b0;
        tick(); tick();
        check_all("pre_rst", RUNNING, 2, 1'b0, 1'b0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check_all("rst_pulse", IDLE, 0, 1'b0, 1'b0);
        tick();
        check_all("rst_arm", ARMED, 0, 1'b0, 1'b0);
        fresh_burst("fresh_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
